vram_writer: RTL and testbench

// - CPU-side VRAM write port: the write end of the VRAM interface the pixel pipeline reads.
// - The CPU sees a 4-register window: 15-bit address pointer, data port and control/status.
// - Writes are queued in a small FIFO and drained into VRAM only on cycles the GPU

---
 rtl/vram_writer.sv | 233 +++++++++++++++++++++++
 tb/tb_vram_writer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_writer.sv
// vram_writer -- CPU-side VRAM write port.
//
// The CPU sees a 4-register window (ADDR_LO, ADDR_HI, DATA, CTRL/STATUS).
// DATA writes are queued in a small FIFO as {addr, data} entries.
// An entry drains into VRAM only on cycles where the GPU grants the write
// port through vram_wr_slot, so pixel fetches are never disturbed.
//
// Optional feature: define VRAM_WRITER_FILL_EN to compile in block fill.
// A CTRL write with bit 7 set then streams the last DATA byte to
// (wdata[6:0]+1) consecutive addresses.
//
// Parameters:
//   DEPTH         FIFO entries (power of two, >= 2)
// Ports:
//   clk           system clock (same clock as VRAM fetches)
//   rst           synchronous reset, active-high
//   cpu_cs        register window select
//   cpu_we        write strobe (qualified by cpu_cs, wins over cpu_re)
//   cpu_re        read strobe (qualified by cpu_cs)
//   cpu_reg       0=ADDR_LO 1=ADDR_HI 2=DATA 3=CTRL/STATUS
//   cpu_wdata     write data
//   cpu_rdata     registered read data
//   vram_wr_slot  GPU grants the VRAM write port this cycle
//   vram_wr_en    VRAM write enable
//   vram_wr_addr  VRAM write address (valid when vram_wr_en=1)
//   vram_wr_data  VRAM write data (valid when vram_wr_en=1)
//   fifo_full     FIFO holds DEPTH entries
module vram_writer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_cs,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic [1:0]  cpu_reg,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic        vram_wr_slot,
  output logic        vram_wr_en,
  output logic [14:0] vram_wr_addr,
  output logic [7:0]  vram_wr_data,
  output logic        fifo_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] REG_ADDR_LO = 2'd0;
  localparam logic [1:0] REG_ADDR_HI = 2'd1;
  localparam logic [1:0] REG_DATA    = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  logic [14:0]   ptr;
  logic [1:0]    inc_code;
  logic [14:0]   inc_amt;
  logic          ovf;
  logic          busy;

  logic [22:0]   mem [DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [CW-1:0] count;
  logic [2:0]    count_sat;
  logic          empty;

  logic          cpu_wr;
  logic          cpu_rd;
  logic          cpu_data_wr;
  logic          cpu_ctrl_wr;
  logic          cpu_push_req;
  logic          fill_push_req;
  logic          push_req;
  logic          push_ok;
  logic [7:0]    push_byte;
  logic          pop;
  logic          inc_wr;
  logic          ovf_set;
  logic          ovf_clr;

  // A write strobe takes priority over a simultaneous read strobe.
  assign cpu_wr      = cpu_cs & cpu_we;
  assign cpu_rd      = cpu_cs & cpu_re & ~cpu_we;
  assign cpu_data_wr = cpu_wr & (cpu_reg == REG_DATA);
  assign cpu_ctrl_wr = cpu_wr & (cpu_reg == REG_CTRL);

  assign empty     = (count == '0);
  assign fifo_full = (count == CW'(DEPTH));

  // Drain straight from the FIFO head; suppressed while reset is asserted.
  assign pop          = vram_wr_slot & ~empty & ~rst;
  assign vram_wr_en   = pop;
  assign vram_wr_addr = mem[rd_idx][22:8];
  assign vram_wr_data = mem[rd_idx][7:0];

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign cpu_push_req = cpu_data_wr & ~busy;
  assign push_req     = cpu_push_req | fill_push_req;
  assign push_ok      = push_req & (~fifo_full | pop);

  // Refused CPU pushes and CPU DATA/CTRL writes during a fill flag overflow.
  assign ovf_set = (cpu_push_req & ~push_ok) | (busy & (cpu_data_wr | cpu_ctrl_wr));
  assign ovf_clr = cpu_rd & (cpu_reg == REG_CTRL);

  generate
    if (CW > 3) begin : g_sat
      assign count_sat = (count > CW'(7)) ? 3'd7 : count[2:0];
    end else begin : g_nosat
      assign count_sat = 3'(count);
    end
  endgenerate

  always_comb begin
    inc_amt = 15'd1;
    case (inc_code)
      2'd0: inc_amt = 15'd1;
      2'd1: inc_amt = 15'd8;
      2'd2: inc_amt = 15'd32;
      2'd3: inc_amt = 15'd0;
      default: inc_amt = 15'd1;
    endcase
  end

`ifdef VRAM_WRITER_FILL_EN
  typedef enum logic {IDLE, FILL} fill_state_e;

  fill_state_e state_q;
  fill_state_e state_d;
  logic [7:0]  remaining;
  logic [7:0]  fill_byte;
  logic        fill_start;

  assign fill_start    = cpu_ctrl_wr & cpu_wdata[7] & ~busy;
  assign inc_wr        = cpu_ctrl_wr & ~cpu_wdata[7] & ~busy;
  assign fill_push_req = busy;
  assign push_byte     = busy ? fill_byte : cpu_wdata;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // The fill ends on the edge that accepts its last push.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fill_start) state_d = FILL;
      FILL:    if (push_ok && remaining == 8'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == FILL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= 8'd0;
      fill_byte <= 8'd0;
    end else begin
      if (fill_start)
        remaining <= {1'b0, cpu_wdata[6:0]} + 8'd1;
      else if (busy && push_ok)
        remaining <= remaining - 8'd1;
      if (cpu_push_req)
        fill_byte <= cpu_wdata;
    end
  end
`else
  assign busy          = 1'b0;
  assign inc_wr        = cpu_ctrl_wr;
  assign fill_push_req = 1'b0;
  assign push_byte     = cpu_wdata;
`endif

  // Address pointer: advances on every accepted push, else loads from ADDR writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 15'd0;
    end else if (push_ok) begin
      ptr <= ptr + inc_amt;
    end else if (cpu_wr && !busy && cpu_reg == REG_ADDR_LO) begin
      ptr[7:0] <= cpu_wdata;
    end else if (cpu_wr && !busy && cpu_reg == REG_ADDR_HI) begin
      ptr[14:8] <= cpu_wdata[6:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         inc_code <= 2'd0;
    else if (inc_wr) inc_code <= cpu_wdata[1:0];
  end

  // A new overflow on the same edge as a STATUS read wins over the clear.
  always_ff @(posedge clk) begin
    if (rst)          ovf <= 1'b0;
    else if (ovf_set) ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_idx] <= {ptr, push_byte};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_idx <= wr_idx + 1'b1;
      if (pop)     rd_idx <= rd_idx + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rdata <= 8'd0;
    end else if (cpu_rd) begin
      case (cpu_reg)
        REG_ADDR_LO: cpu_rdata <= ptr[7:0];
        REG_ADDR_HI: cpu_rdata <= {1'b0, ptr[14:8]};
        REG_DATA:    cpu_rdata <= 8'h00;
        REG_CTRL:    cpu_rdata <= {ovf, busy, fifo_full, empty, 1'b0, count_sat};
        default:     cpu_rdata <= 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_writer.sv
// tb_vram_writer -- directed self-checking bench for vram_writer (DEPTH=4).
module tb_vram_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_cs = 1'b0;
  logic        cpu_we = 1'b0;
  logic        cpu_re = 1'b0;
  logic [1:0]  cpu_reg = 2'd0;
  logic [7:0]  cpu_wdata = 8'd0;
  logic [7:0]  cpu_rdata;
  logic        vram_wr_slot = 1'b0;
  logic        vram_wr_en;
  logic [14:0] vram_wr_addr;
  logic [7:0]  vram_wr_data;
  logic        fifo_full;

  int vectors = 0;
  int miscompares = 0;

  logic [14:0] log_addr[$];
  logic [7:0]  log_data[$];

  vram_writer #(.DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .cpu_cs(cpu_cs),
    .cpu_we(cpu_we),
    .cpu_re(cpu_re),
    .cpu_reg(cpu_reg),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .vram_wr_slot(vram_wr_slot),
    .vram_wr_en(vram_wr_en),
    .vram_wr_addr(vram_wr_addr),
    .vram_wr_data(vram_wr_data),
    .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (vram_wr_en === 1'b1) begin
      log_addr.push_back(vram_wr_addr);
      log_data.push_back(vram_wr_data);
    end
  end

  task cpu_write(input logic [1:0] r, input logic [7:0] d);
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_re = 1'b0; cpu_reg = r; cpu_wdata = d;
    @(posedge clk); #1;
    cpu_cs = 1'b0; cpu_we = 1'b0;
  endtask

  task cpu_read(input logic [1:0] r, output logic [7:0] d);
    cpu_cs = 1'b1; cpu_re = 1'b1; cpu_we = 1'b0; cpu_reg = r;
    @(posedge clk); #1;
    d = cpu_rdata;
    cpu_cs = 1'b0; cpu_re = 1'b0;
  endtask

  task test_reset;
    logic [7:0] d;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    vectors++;
    if (cpu_rdata !== 8'h00) begin
      miscompares++; $display("[TB] FAIL reset_rdata: got %h expected 00", cpu_rdata);
    end
    vram_wr_slot = 1'b1; #1;
    vectors++;
    if (vram_wr_en !== 1'b0 || fifo_full !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_empty: wr_en %b full %b expected 0 0", vram_wr_en, fifo_full);
    end
    vram_wr_slot = 1'b0;
    cpu_read(2'd3, d);
    vectors++;
    if (d !== 8'h10) begin
      miscompares++; $display("[TB] FAIL reset_status: got %h expected 10", d);
    end
    cpu_read(2'd0, d);
    vectors++;
    if (d !== 8'h00) begin
      miscompares++; $display("[TB] FAIL reset_ptr_lo: got %h expected 00", d);
    end
  endtask

  task test_single_write;
    logic [7:0] d;
    vram_wr_slot = 1'b1;
    cpu_write(2'd0, 8'h34);
    cpu_write(2'd1, 8'h12);
    cpu_write(2'd2, 8'hAB);
    vectors++;
    if (vram_wr_en !== 1'b1 || vram_wr_addr !== 15'h1234 || vram_wr_data !== 8'hAB) begin
      miscompares++;
      $display("[TB] FAIL single_write: en %b addr %h data %h expected 1 1234 ab", vram_wr_en, vram_wr_addr, vram_wr_data);
    end
    cpu_read(2'd0, d);
    vectors++;
    if (d !== 8'h35) begin
      miscompares++; $display("[TB] FAIL single_ptr_lo: got %h expected 35", d);
    end
    vectors++;
    if (vram_wr_en !== 1'b0) begin
      miscompares++; $display("[TB] FAIL single_drained: wr_en %b expected 0", vram_wr_en);
    end
    cpu_read(2'd1, d);
    vectors++;
    if (d !== 8'h12) begin
      miscompares++; $display("[TB] FAIL single_ptr_hi: got %h expected 12", d);
    end
    cpu_read(2'd2, d);
    vectors++;
    if (d !== 8'h00) begin
      miscompares++; $display("[TB] FAIL data_read: got %h expected 00", d);
    end
    vram_wr_slot = 1'b0;
  endtask

  task test_wrap;
    logic [7:0] d;
    vram_wr_slot = 1'b1;
    cpu_write(2'd3, 8'h01);
    cpu_write(2'd0, 8'hFC);
    cpu_write(2'd1, 8'h7F);
    cpu_write(2'd2, 8'h11);
    vectors++;
    if (vram_wr_en !== 1'b1 || vram_wr_addr !== 15'h7FFC || vram_wr_data !== 8'h11) begin
      miscompares++;
      $display("[TB] FAIL wrap_first: en %b addr %h data %h expected 1 7ffc 11", vram_wr_en, vram_wr_addr, vram_wr_data);
    end
    cpu_write(2'd2, 8'h22);
    vectors++;
    if (vram_wr_en !== 1'b1 || vram_wr_addr !== 15'h0004 || vram_wr_data !== 8'h22) begin
      miscompares++;
      $display("[TB] FAIL wrap_second: en %b addr %h data %h expected 1 0004 22", vram_wr_en, vram_wr_addr, vram_wr_data);
    end
    cpu_read(2'd0, d);
    vectors++;
    if (d !== 8'h0C) begin
      miscompares++; $display("[TB] FAIL wrap_ptr_lo: got %h expected 0c", d);
    end
    cpu_read(2'd1, d);
    vectors++;
    if (d !== 8'h00) begin
      miscompares++; $display("[TB] FAIL wrap_ptr_hi: got %h expected 00", d);
    end
    cpu_write(2'd3, 8'h00);
    vram_wr_slot = 1'b0;
  endtask

  task test_overflow;
    logic [7:0] d;
    vram_wr_slot = 1'b0;
    cpu_write(2'd0, 8'h00);
    cpu_write(2'd1, 8'h02);
    for (int i = 0; i < 5; i++) begin
      cpu_write(2'd2, 8'hA0 + 8'(i));
      if (i == 3) begin
        vectors++;
        if (fifo_full !== 1'b1) begin
          miscompares++; $display("[TB] FAIL ovf_full: got %b expected 1", fifo_full);
        end
      end
    end
    cpu_read(2'd3, d);
    vectors++;
    if (d !== 8'hA4) begin
      miscompares++; $display("[TB] FAIL ovf_status1: got %h expected a4", d);
    end
    cpu_read(2'd3, d);
    vectors++;
    if (d !== 8'h24) begin
      miscompares++; $display("[TB] FAIL ovf_status2: got %h expected 24", d);
    end
    cpu_read(2'd0, d);
    vectors++;
    if (d !== 8'h04) begin
      miscompares++; $display("[TB] FAIL ovf_ptr: got %h expected 04", d);
    end
    vram_wr_slot = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (vram_wr_en !== 1'b1 || vram_wr_addr !== 15'h0200 + 15'(i) || vram_wr_data !== 8'hA0 + 8'(i)) begin
        miscompares++;
        $display("[TB] FAIL ovf_drain%0d: en %b addr %h data %h expected 1 %h %h", i, vram_wr_en,
                 vram_wr_addr, vram_wr_data, 15'h0200 + 15'(i), 8'hA0 + 8'(i));
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (vram_wr_en !== 1'b0) begin
      miscompares++; $display("[TB] FAIL ovf_empty: wr_en %b expected 0", vram_wr_en);
    end
    vram_wr_slot = 1'b0;
    cpu_read(2'd3, d);
    vectors++;
    if (d !== 8'h10) begin
      miscompares++; $display("[TB] FAIL ovf_status3: got %h expected 10", d);
    end
  endtask

  task test_full_push_pop;
    logic [7:0] d;
    vram_wr_slot = 1'b0;
    cpu_write(2'd0, 8'h00);
    cpu_write(2'd1, 8'h03);
    for (int i = 0; i < 4; i++) cpu_write(2'd2, 8'hB0 + 8'(i));
    vram_wr_slot = 1'b1; #1;
    vectors++;
    if (vram_wr_en !== 1'b1 || vram_wr_addr !== 15'h0300 || fifo_full !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL pp_head: en %b addr %h full %b expected 1 0300 1", vram_wr_en, vram_wr_addr, fifo_full);
    end
    cpu_write(2'd2, 8'hB4);
    vram_wr_slot = 1'b0;
    vectors++;
    if (fifo_full !== 1'b1) begin
      miscompares++; $display("[TB] FAIL pp_full: got %b expected 1", fifo_full);
    end
    cpu_read(2'd3, d);
    vectors++;
    if (d !== 8'h24) begin
      miscompares++; $display("[TB] FAIL pp_status: got %h expected 24", d);
    end
    vram_wr_slot = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (vram_wr_en !== 1'b1 || vram_wr_addr !== 15'h0301 + 15'(i) || vram_wr_data !== 8'hB1 + 8'(i)) begin
        miscompares++;
        $display("[TB] FAIL pp_drain%0d: en %b addr %h data %h expected 1 %h %h", i, vram_wr_en,
                 vram_wr_addr, vram_wr_data, 15'h0301 + 15'(i), 8'hB1 + 8'(i));
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (vram_wr_en !== 1'b0) begin
      miscompares++; $display("[TB] FAIL pp_empty: wr_en %b expected 0", vram_wr_en);
    end
    vram_wr_slot = 1'b0;
  endtask

`ifdef VRAM_WRITER_FILL_EN
  task test_fill;
    logic [7:0] d;
    int cycles;
    vram_wr_slot = 1'b1;
    cpu_write(2'd0, 8'h00);
    cpu_write(2'd1, 8'h01);
    log_addr.delete();
    log_data.delete();
    cpu_write(2'd2, 8'h55);
    cpu_write(2'd3, 8'h82);
    cpu_read(2'd3, d);
    vectors++;
    if (d !== 8'h50) begin
      miscompares++; $display("[TB] FAIL fill_busy: got %h expected 50", d);
    end
    cycles = 0;
    while (log_addr.size() < 4 && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    vectors++;
    if (log_addr.size() != 4) begin
      miscompares++; $display("[TB] FAIL fill_count: got %0d writes expected 4", log_addr.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (log_addr.size() > i) begin
        vectors++;
        if (log_addr[i] !== 15'h0100 + 15'(i) || log_data[i] !== 8'h55) begin
          miscompares++;
          $display("[TB] FAIL fill_write%0d: addr %h data %h expected %h 55", i, log_addr[i],
                   log_data[i], 15'h0100 + 15'(i));
        end
      end
    end
    cpu_read(2'd3, d);
    vectors++;
    if (d !== 8'h10) begin
      miscompares++; $display("[TB] FAIL fill_done: got %h expected 10", d);
    end
    cpu_read(2'd0, d);
    vectors++;
    if (d !== 8'h04) begin
      miscompares++; $display("[TB] FAIL fill_ptr: got %h expected 04", d);
    end
    vram_wr_slot = 1'b0;
  endtask
`else
  task test_fill;
    logic [7:0] d;
    vram_wr_slot = 1'b1;
    cpu_write(2'd0, 8'h00);
    cpu_write(2'd1, 8'h01);
    cpu_write(2'd3, 8'h82);
    cpu_read(2'd3, d);
    vectors++;
    if (d !== 8'h10) begin
      miscompares++; $display("[TB] FAIL nofill_status: got %h expected 10", d);
    end
    cpu_write(2'd2, 8'h66);
    vectors++;
    if (vram_wr_en !== 1'b1 || vram_wr_addr !== 15'h0100 || vram_wr_data !== 8'h66) begin
      miscompares++;
      $display("[TB] FAIL nofill_write: en %b addr %h data %h expected 1 0100 66", vram_wr_en, vram_wr_addr, vram_wr_data);
    end
    cpu_read(2'd0, d);
    vectors++;
    if (d !== 8'h20) begin
      miscompares++; $display("[TB] FAIL nofill_inc32: got %h expected 20", d);
    end
    cpu_write(2'd3, 8'h00);
    vram_wr_slot = 1'b0;
  endtask
`endif

  task test_reset_mid;
    logic [7:0] d;
    vram_wr_slot = 1'b0;
    cpu_write(2'd2, 8'h77);
    cpu_write(2'd2, 8'h78);
    rst = 1'b1;
    vram_wr_slot = 1'b1; #1;
    vectors++;
    if (vram_wr_en !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rst_cycle_wr_en: got %b expected 0", vram_wr_en);
    end
    @(posedge clk); #1;
    rst = 1'b0; #1;
    vectors++;
    if (vram_wr_en !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rst_discard: wr_en %b expected 0", vram_wr_en);
    end
    cpu_read(2'd3, d);
    vectors++;
    if (d !== 8'h10) begin
      miscompares++; $display("[TB] FAIL rst_status: got %h expected 10", d);
    end
    cpu_read(2'd1, d);
    vectors++;
    if (d !== 8'h00) begin
      miscompares++; $display("[TB] FAIL rst_ptr_hi: got %h expected 00", d);
    end
    cpu_write(2'd2, 8'h99);
    cpu_read(2'd0, d);
    vectors++;
    if (d !== 8'h01) begin
      miscompares++; $display("[TB] FAIL rst_inc: got %h expected 01", d);
    end
    vram_wr_slot = 1'b0;
  endtask

  initial begin
    $display("[TB] starting vram_writer directed tests");
    test_reset();
    test_single_write();
    test_wrap();
    test_overflow();
    test_full_push_pop();
    test_fill();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
